// File: rtl/pbpix_tx_pkg.sv
// Shared types and helpers for the pbpix transmitter: FSM state encoding and
// the frame-counter width calculation.
package PbpixPkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } PbpixTxState;

   // Counters run 0..n inclusive, so they need room for n itself.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pbpix_tx_fifo2.sv
// Two-entry register FIFO; entry 0 is the head and feeds the outputs directly.
// A push is refused while full, even when a pop happens in the same cycle.
module pbpix_fifo2 #(
   parameter int W = 9
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem0_q, mem0_d;
   logic [W-1:0] mem1_q, mem1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         push_ok;
   logic         pop_ok;

   assign full  = (cnt_q == 2'd2);
   assign empty = (cnt_q == 2'd0);
   assign head  = mem0_q;

   always_comb begin
      mem0_d  = mem0_q;
      mem1_d  = mem1_q;
      cnt_d   = cnt_q;
      push_ok = push && !full;
      pop_ok  = pop && !empty;
      case ({push_ok, pop_ok})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               mem0_d = wdata;
            end else begin
               mem1_d = wdata;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            // Shift the second entry forward; clear the head when draining out.
            if (cnt_q == 2'd2) begin
               mem0_d = mem1_q;
            end else begin
               mem0_d = '0;
            end
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            // Only reachable with one entry: the new word replaces the head.
            mem0_d = wdata;
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mem0_q <= '0;
         mem1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         mem0_q <= mem0_d;
         mem1_q <= mem1_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/pbpix_tx.sv
// pbpix transmitter: rdy/ack pixel words in, zero-flagged pbpix words out,
// with per-frame counting. Define PBPIX_ZCNT_EN to add the o_zero_cnt output.
module pbpix_tx
   import PbpixPkg::*;
#(
   parameter  int DW        = 8,
   parameter  int FRAME_LEN = 64,
   localparam int CW        = cnt_width(FRAME_LEN)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          src_rdy,
   output logic          src_ack,
   input  logic [DW-1:0] src_data,
   output logic          pix_rdy,
   input  logic          pix_ack,
   output logic          pix_zero,
   output logic [DW-1:0] pix_data,
   output logic          pix_last,
   output logic          o_frame_done,
   output logic          o_busy
`ifdef PBPIX_ZCNT_EN
   ,
   output logic [CW-1:0] o_zero_cnt
`endif
);

   localparam logic [CW-1:0] LEN      = CW'(FRAME_LEN);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   PbpixTxState   state_q, state_d;
   logic [CW-1:0] in_cnt_q, in_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic          fifo_full;
   logic          fifo_empty;
   logic          in_xfer;
   logic          out_xfer;
   logic          wr_zero;
   logic [DW:0]   wr_word;
   logic [DW:0]   head;

   always_comb begin
      wr_zero  = (src_data == {DW{1'b0}});
      wr_word  = {wr_zero, (wr_zero ? {DW{1'b0}} : src_data)};
      src_ack  = src_rdy && !fifo_full && (state_q != DONE) && (in_cnt_q < LEN);
      in_xfer  = src_ack;
      out_xfer = pix_rdy && pix_ack;
   end

   pbpix_fifo2 #(
      .W(DW + 1)
   ) u_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .push  (in_xfer),
      .pop   (out_xfer),
      .wdata (wr_word),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign pix_rdy              = !fifo_empty;
   assign {pix_zero, pix_data} = head;
   assign pix_last             = pix_rdy && (out_cnt_q == LAST_IDX);
   assign o_frame_done         = (state_q == DONE);
   assign o_busy               = (state_q != IDLE);

   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      if (in_xfer) begin
         in_cnt_d = in_cnt_q + CW'(1);
      end else begin
         in_cnt_d = in_cnt_q;
      end
      if (out_xfer) begin
         out_cnt_d = out_cnt_q + CW'(1);
      end else begin
         out_cnt_d = out_cnt_q;
      end
      case (state_q)
         IDLE: begin
            if (in_xfer) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (out_xfer && pix_last) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d   = IDLE;
            in_cnt_d  = '0;
            out_cnt_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

`ifdef PBPIX_ZCNT_EN
   logic [CW-1:0] zcnt_q, zcnt_d;

   // Holds through DONE so it can be read with the frame-done pulse.
   always_comb begin
      if (state_q == DONE) begin
         zcnt_d = '0;
      end else if (out_xfer && pix_zero) begin
         zcnt_d = zcnt_q + CW'(1);
      end else begin
         zcnt_d = zcnt_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         zcnt_q <= '0;
      end else begin
         zcnt_q <= zcnt_d;
      end
   end

   assign o_zero_cnt = zcnt_q;
`endif

endmodule

// File: tb/tb_pbpix_tx.sv
// Directed and randomized self-checking bench for pbpix_tx with FRAME_LEN=4.
module tb_pbpix_tx;

   localparam int DW = 8;
   localparam int FL = 4;
   localparam int CW = $clog2(FL + 1);

   logic          clk = 1'b0;
   logic          i_rst;
   logic          src_rdy;
   logic          src_ack;
   logic [DW-1:0] src_data;
   logic          pix_rdy;
   logic          pix_ack;
   logic          pix_zero;
   logic [DW-1:0] pix_data;
   logic          pix_last;
   logic          o_frame_done;
   logic          o_busy;
`ifdef PBPIX_ZCNT_EN
   logic [CW-1:0] o_zero_cnt;
`endif

   int n_checks;
   int n_fail;

   always #5 clk = ~clk;

   pbpix_tx #(
      .DW(DW),
      .FRAME_LEN(FL)
   ) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .src_rdy      (src_rdy),
      .src_ack      (src_ack),
      .src_data     (src_data),
      .pix_rdy      (pix_rdy),
      .pix_ack      (pix_ack),
      .pix_zero     (pix_zero),
      .pix_data     (pix_data),
      .pix_last     (pix_last),
      .o_frame_done (o_frame_done),
      .o_busy       (o_busy)
`ifdef PBPIX_ZCNT_EN
      ,
      .o_zero_cnt   (o_zero_cnt)
`endif
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic obs();
      @(negedge clk);
   endtask

   task automatic drain(input string nm);
      int  c;
      bit  extra;
      extra = 1'b0;
      c = 0;
      do begin
         cyc();
         src_rdy = 1'b0;
         pix_ack = 1'b1;
         obs();
         if (pix_rdy) extra = 1'b1;
         c++;
      end while (o_busy && c < 10);
      n_checks++;
      if (o_busy || extra) begin
         n_fail++;
         $display("FAIL %s_drain: busy=%0b extra_word=%0b, required busy=0 extra_word=0", nm, o_busy, extra);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      src_rdy = 1'b0;
      pix_ack = 1'b0;
      src_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b0;
      obs();
      n_checks++;
      if ({src_ack, pix_rdy, pix_zero, pix_data, pix_last, o_frame_done, o_busy} !== 14'h0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, required 0000",
                  {src_ack, pix_rdy, pix_zero, pix_data, pix_last, o_frame_done, o_busy});
      end
`ifdef PBPIX_ZCNT_EN
      n_checks++;
      if (o_zero_cnt !== CW'(0)) begin
         n_fail++;
         $display("FAIL reset_zcnt: got %0d, required 0", o_zero_cnt);
      end
`endif
   endtask

   // Sends four words back-to-back with pix_ack high and checks every cycle.
   task automatic send_frame(input string nm, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3);
      logic [7:0] w[4];
      logic       zf;
      logic [10:0] got;
      logic [10:0] req;
      int         nz;
      w = '{w0, w1, w2, w3};
      nz = 0;
      for (int k = 0; k < 4; k++) if (w[k] == 8'h00) nz++;
      for (int i = 0; i < 7; i++) begin
         cyc();
         src_rdy  = (i < 4);
         src_data = (i < 4) ? w[i] : 8'h00;
         pix_ack  = 1'b1;
         obs();
         if (i < 4) begin
            n_checks++;
            if (src_ack !== 1'b1) begin
               n_fail++;
               $display("FAIL %s_ack%0d: got %b, required 1", nm, i, src_ack);
            end
         end
         if (i >= 1 && i <= 4) begin
            zf  = (w[i-1] == 8'h00);
            got = {pix_rdy, pix_zero, pix_data, pix_last};
            req = {1'b1, zf, (zf ? 8'h00 : w[i-1]), (i == 4)};
            n_checks++;
            if (got !== req) begin
               n_fail++;
               $display("FAIL %s_word%0d: rdy/zero/data/last got %h, required %h", nm, i - 1, got, req);
            end
         end
         if (i == 5) begin
            n_checks++;
            if ({pix_rdy, o_frame_done, o_busy} !== 3'b011) begin
               n_fail++;
               $display("FAIL %s_done: rdy/done/busy got %b, required 011", nm, {pix_rdy, o_frame_done, o_busy});
            end
`ifdef PBPIX_ZCNT_EN
            n_checks++;
            if (o_zero_cnt !== CW'(nz)) begin
               n_fail++;
               $display("FAIL %s_zcnt: got %0d, required %0d", nm, o_zero_cnt, nz);
            end
`endif
         end
         if (i == 6) begin
            n_checks++;
            if ({o_frame_done, o_busy} !== 2'b00) begin
               n_fail++;
               $display("FAIL %s_idle: done/busy got %b, required 00", nm, {o_frame_done, o_busy});
            end
         end
      end
      src_rdy = 1'b0;
   endtask

   task automatic test_basic();
      send_frame("basic", 8'd5, 8'd0, 8'd7, 8'd0);
   endtask

   task automatic test_values();
      send_frame("values", 8'hFF, 8'h00, 8'h80, 8'h01);
   endtask

   task automatic test_backpressure();
      logic [7:0] w[4];
      int         nacc;
      int         npop;
      logic [8:0] req;
      w = '{8'd5, 8'd0, 8'd7, 8'd9};
      nacc = 0;
      npop = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         src_rdy  = 1'b1;
         src_data = w[nacc];
         pix_ack  = 1'b0;
         obs();
         n_checks++;
         if (src_ack !== (i < 2)) begin
            n_fail++;
            $display("FAIL bp_ack%0d: got %b, required %b", i, src_ack, (i < 2));
         end
         if (src_rdy && src_ack) nacc++;
         if (i >= 1) begin
            n_checks++;
            if ({pix_rdy, pix_zero, pix_data} !== {1'b1, 1'b0, 8'd5}) begin
               n_fail++;
               $display("FAIL bp_hold%0d: rdy/zero/data got %h, required 105", i, {pix_rdy, pix_zero, pix_data});
            end
         end
      end
      for (int c = 0; c < 20 && npop < 4; c++) begin
         cyc();
         src_rdy  = (nacc < 4);
         src_data = (nacc < 4) ? w[nacc] : 8'h00;
         pix_ack  = 1'b1;
         obs();
         if (pix_rdy) begin
            req = {(w[npop] == 8'h00), w[npop]};
            n_checks++;
            if ({pix_zero, pix_data} !== req) begin
               n_fail++;
               $display("FAIL bp_order%0d: got %h, required %h", npop, {pix_zero, pix_data}, req);
            end
            npop++;
         end
         if (src_rdy && src_ack) nacc++;
      end
      n_checks++;
      if (npop != 4 || nacc != 4) begin
         n_fail++;
         $display("FAIL bp_count: popped %0d accepted %0d, required 4 and 4", npop, nacc);
      end
      drain("bp");
   endtask

   task automatic test_frame_boundary();
      logic [7:0] w[8];
      bit         ea[12];
      bit         ed[12];
      int         ns;
      w  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd10, 8'd11, 8'd12};
      ea = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      ns = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         src_rdy  = (ns < 8);
         src_data = (ns < 8) ? w[ns] : 8'h00;
         pix_ack  = 1'b1;
         obs();
         n_checks++;
         if ({src_ack, o_frame_done} !== {ea[i], ed[i]}) begin
            n_fail++;
            $display("FAIL fb_cycle%0d: ack/done got %b%b, required %b%b", i, src_ack, o_frame_done, ea[i], ed[i]);
         end
         if (i == 4 || i == 7 || i == 10) begin
            n_checks++;
            if ({pix_rdy, pix_data, pix_last} !== {1'b1, w[(i == 4) ? 3 : ((i == 7) ? 4 : 7)], (i != 7)}) begin
               n_fail++;
               $display("FAIL fb_pix%0d: rdy/data/last got %h", i, {pix_rdy, pix_data, pix_last});
            end
         end
         if (src_rdy && src_ack) ns++;
      end
      drain("fb");
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 2; i++) begin
         cyc();
         src_rdy  = 1'b1;
         src_data = 8'(i + 3);
         pix_ack  = 1'b0;
         obs();
         n_checks++;
         if (src_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_ack%0d: got %b, required 1", i, src_ack);
         end
      end
      cyc();
      src_rdy = 1'b0;
      i_rst   = 1'b1;
      cyc();
      i_rst = 1'b0;
      obs();
      n_checks++;
      if ({src_ack, pix_rdy, pix_zero, pix_data, pix_last, o_frame_done, o_busy} !== 14'h0000) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got %h, required 0000",
                  {src_ack, pix_rdy, pix_zero, pix_data, pix_last, o_frame_done, o_busy});
      end
      cyc();
      obs();
      n_checks++;
      if ({pix_rdy, o_frame_done, o_busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_mid_nodone: rdy/done/busy got %b, required 000", {pix_rdy, o_frame_done, o_busy});
      end
      send_frame("after_rst", 8'd3, 8'd0, 8'd0, 8'd6);
   endtask

   task automatic test_random();
      logic [8:0] q[$];
      logic [8:0] exp_w;
      logic [8:0] hold_w;
      logic       hold_v;
      logic [7:0] d;
      int         nout;
      int         ndone;
      int         cycles;
      int         zc;
      nout = 0;
      ndone = 0;
      cycles = 0;
      zc = 0;
      hold_v = 1'b0;
      hold_w = 9'h000;
      while (ndone < 1000 && cycles < 40000) begin
         cyc();
         cycles++;
         d        = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255));
         src_rdy  = ($urandom_range(3) != 0);
         src_data = d;
         pix_ack  = ($urandom_range(3) != 0);
         obs();
         if (hold_v) begin
            n_checks++;
            if (!pix_rdy || {pix_zero, pix_data} !== hold_w) begin
               n_fail++;
               $display("FAIL rnd_stable: rdy=%b word=%h, required rdy=1 word=%h", pix_rdy, {pix_zero, pix_data}, hold_w);
            end
         end
         hold_v = pix_rdy && !pix_ack;
         hold_w = {pix_zero, pix_data};
         if (pix_rdy && pix_ack) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL rnd_spurious: word %h with empty scoreboard", {pix_zero, pix_data});
            end else begin
               exp_w = q.pop_front();
               if ({pix_zero, pix_data} !== exp_w || pix_last !== ((nout % 4) == 3)) begin
                  n_fail++;
                  $display("FAIL rnd_word%0d: word/last got %h/%b, required %h/%b",
                           nout, {pix_zero, pix_data}, pix_last, exp_w, ((nout % 4) == 3));
               end
            end
            if (pix_zero) zc++;
            nout++;
         end
         if (src_rdy && src_ack) q.push_back({(d == 8'h00), d});
         if (o_frame_done) begin
            n_checks++;
            if (nout != (ndone + 1) * 4) begin
               n_fail++;
               $display("FAIL rnd_done%0d: words out %0d, required %0d", ndone, nout, (ndone + 1) * 4);
            end
`ifdef PBPIX_ZCNT_EN
            n_checks++;
            if (o_zero_cnt !== CW'(zc)) begin
               n_fail++;
               $display("FAIL rnd_zcnt%0d: got %0d, required %0d", ndone, o_zero_cnt, zc);
            end
`endif
            zc = 0;
            ndone++;
         end
      end
      n_checks++;
      if (ndone != 1000 || q.size() != 0) begin
         n_fail++;
         $display("FAIL rnd_total: frames %0d leftover %0d, required 1000 and 0", ndone, q.size());
      end
      drain("rnd");
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      i_rst    = 1'b1;
      src_rdy  = 1'b0;
      src_data = 8'h00;
      pix_ack  = 1'b0;
      test_reset();
      test_basic();
      test_values();
      test_backpressure();
      test_frame_boundary();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pbpix_tx.md
Name: pbpix_tx

Overview:
- Transmitting end of the pbpix handshake (rdy/ack/zero).
- Accepts dense pixel words on a rdyack input and emits them on a pbpix output.
- Flags zero-valued pixels on the zero line and gates the data lane to 0 for them.
- Counts pixels per frame, marks the last pixel, and pulses frame-done. Sits between a feature-map buffer reader and a zero-aware PE array input.

Parameters:
- DW, 8, pixel data width in bits.
- FRAME_LEN, 64, pixels per frame; must be 2 or more.
- CW, $clog2(FRAME_LEN+1), localparam: counter width.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous reset, active-high.
- src_rdy  input  1  upstream word valid.
- src_ack  output  1  word accepted this cycle.
- src_data  input  DW  upstream pixel.
- pix_rdy  output  1  pbpix word valid.
- pix_ack  input  1  downstream accepts.
- pix_zero  output  1  current pixel is zero.
- pix_data  output  DW  pixel value; 0 whenever pix_zero=1.
- pix_last  output  1  current pixel is the frame's last.
- o_frame_done  output  1  one-cycle pulse after the last transfer.
- o_busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (i_rst=1 at a clock edge): all outputs 0, buffer empty, counters 0, state IDLE. Reset aborts any frame mid-operation and discards buffered words; no frame_done is issued.
- Transfers: input transfer when src_rdy&&src_ack; output transfer when pix_rdy&&pix_ack.
- src_ack is combinational from src_rdy, buffer-not-full, state!=DONE, and in_cnt<FRAME_LEN. It never depends on pix_ack.
- Buffer: 2 entries, each holding {zero, data}. zero=(src_data==0) is computed on write; stored data is forced to 0 when zero=1.
- Outputs pix_rdy, pix_zero, pix_data and pix_last come directly from the head register. Nothing combinational passes from src to pix.
- Latency: a word accepted in cycle t is presented on pix in cycle t+1 when the buffer was empty.
- Throughput: 1 word per cycle when pix_ack stays high.
- Full buffer: no push that cycle, even if a pop occurs in the same cycle.
- Simultaneous push and pop with exactly 1 entry: occupancy stays at 1 and the head advances.
- Once pix_rdy=1, pix_rdy and the head contents must hold stable until an output transfer.
- in_cnt counts input transfers and out_cnt counts output transfers, both in 0..FRAME_LEN. pix_last = pix_rdy && out_cnt==FRAME_LEN-1.
- FSM:
  - IDLE -> RUN on the first input transfer.
  - RUN -> DONE on the output transfer with pix_last=1.
  - DONE -> IDLE unconditionally after 1 cycle.
  - In DONE: o_frame_done=1, src_ack=0, both counters clear to 0.
- After FRAME_LEN input transfers, src_ack stays 0 until the FSM returns to IDLE. This gives a minimum 1-cycle bubble between frames.
- pix_ack while pix_rdy=0 is ignored.

Optional Feature:
- Macro: PBPIX_ZCNT_EN.
- Defined: adds output o_zero_cnt [CW-1:0], the count of output transfers with pix_zero=1 in the current frame.
  - Valid when o_frame_done=1.
  - Holds its value through DONE and clears on the DONE->IDLE transition.
  - Saturation is impossible by construction (count ≤ FRAME_LEN).
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package PbpixPkg holds:
  - typedef enum {IDLE, RUN, DONE} PbpixTxState;
  - a function to compute counter width.
- Sub-module pbpix_fifo2: 2-entry register FIFO with push/pop/full/empty and a head output, parameterised by width (DW+1).

Test Plan:
- FRAME_LEN=4, src sends 5,0,7,0 back-to-back, pix_ack=1:
  - pix emits zero=0/5, 1/0, 0/7, 1/0 on consecutive cycles t+1..t+4.
  - pix_last only on the 4th word; o_frame_done pulses at t+5.
  - With PBPIX_ZCNT_EN, o_zero_cnt=2.
- Backpressure, pix_ack=0 for 5 cycles:
  - src_ack drops after 2 accepts.
  - pix_data=5 stays stable.
  - After pix_ack=1, all 4 words arrive in order with no loss or duplication.
- Frame boundary, src_rdy held high across frames: the 5th word is not acked until the cycle after the frame_done pulse, and then starts frame 2 with out_cnt=0.
- Input pixel 0xFF: pix_zero=0, pix_data=0xFF. Input 0x00: pix_zero=1, pix_data=0x00.
- i_rst=1 for one cycle mid-frame after 2 of 4 words:
  - next cycle all outputs 0, buffer empty, no frame_done.
  - a new 4-word frame then completes normally.
- Random rdy/ack toggling over 1000 frames: the scoreboard matches input order and zero flags, with exactly one frame_done per 4 words.
